// File: rtl/pad_mapper.sv
// pad_mapper: MiST joystick bits -> Aquarius active-low hand-controller bytes,
// with per-bit sync, debounce, autofire and change strobe. `PAD_SWAP_EN adds a swap input.
module pad_mapper #(
  parameter int unsigned NUM_PADS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned AUTOFIRE_DIV    = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef PAD_SWAP_EN
  input  logic                    swap,
`endif
  input  logic [8*NUM_PADS-1:0]   joy_in,
  input  logic [4*NUM_PADS-1:0]   autofire_en,
  output logic [8*NUM_PADS-1:0]   pad_out,
  output logic [NUM_PADS-1:0]     pad_changed
);

  localparam int unsigned NB = 8 * NUM_PADS;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned AW = $clog2(AUTOFIRE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AF_LAST  = AW'(AUTOFIRE_DIV - 1);

  logic [NB-1:0]       sync1;
  logic [NB-1:0]       sync2;
  logic [NB-1:0]       deb;
  logic [CW-1:0]       cnt [NB];
  logic [AW-1:0]       af_cnt;
  logic                af_phase;
  logic                swap_sel;
  logic [NB-1:0]       eff_c;
  logic [NB-1:0]       src_c;
  logic [NB-1:0]       enc_c;
  logic [NUM_PADS-1:0] chg_c;

  // Active-high joystick bits to active-low hand-controller byte.
  function automatic logic [7:0] encode(input logic [7:0] b);
    logic [7:0] r;
    r = 8'hFF;
    if (b[0]) r = r & 8'hFD;
    if (b[1]) r = r & 8'hF7;
    if (b[2]) r = r & 8'hFE;
    if (b[3]) r = r & 8'hFB;
    if (b[4]) r = r & 8'hBF;
    if (b[5]) r = r & 8'hDF;
    if (b[6]) r = r & 8'h5F;
    if (b[7]) r = r & 8'h7B;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= joy_in;
      sync2 <= sync1;
    end
  end

`ifdef PAD_SWAP_EN
  logic swap_s1;
  logic swap_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      swap_s1 <= 1'b0;
      swap_s2 <= 1'b0;
    end else begin
      swap_s1 <= swap;
      swap_s2 <= swap_s1;
    end
  end

  assign swap_sel = swap_s2;
`else
  assign swap_sel = 1'b0;
`endif

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int b = 0; b < NB; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (sync2[b] == deb[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          deb[b] <= sync2[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + AW'(1);
    end
  end

  // Buttons gated by the shared autofire phase; directions pass straight through.
  always_comb begin
    eff_c = deb;
    for (int p = 0; p < NUM_PADS; p++) begin
      eff_c[8*p+4 +: 4] = deb[8*p+4 +: 4] & ({4{af_phase}} | ~autofire_en[4*p +: 4]);
    end
  end

  always_comb begin
    src_c = eff_c;
    if (swap_sel) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        src_c[8*p +: 8] = eff_c[8*(NUM_PADS-1-p) +: 8];
      end
    end
  end

  always_comb begin
    enc_c = '1;
    chg_c = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      enc_c[8*p +: 8] = encode(src_c[8*p +: 8]);
      chg_c[p]        = (enc_c[8*p +: 8] != pad_out[8*p +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pad_out     <= '1;
      pad_changed <= '0;
    end else begin
      pad_out     <= enc_c;
      pad_changed <= chg_c;
    end
  end

endmodule
